// File: rtl/exp_fixed_pkg.sv
// Shared constants and coefficient helpers for the fixed-point e^x pipeline.
// Coefficients are round(2^IF / k!) with IF = 2*WIDTH-4 fractional bits.
package exp_fixed_pkg;

    localparam int TERMS_MIN = 2;
    localparam int TERMS_MAX = 8;

    function automatic int if_bits(input int width);
        return 2 * width - 4;
    endfunction

    function automatic logic [63:0] fact(input int k);
        logic [63:0] f;
        f = 64'd1;
        for (int i = 2; i <= k; i++) begin
            f = f * 64'(i);
        end
        return f;
    endfunction

    function automatic logic [63:0] coef(input int width, input int k);
        logic [63:0] f;
        f = fact(k);
        return ((64'd1 << if_bits(width)) + (f >> 1)) / f;
    endfunction

endpackage

// File: rtl/exp_horner_stage.sv
// One registered Horner step: acc <= round(acc * x >> FRAC) + c_K.
// Holds all state while advance is low.
module exp_horner_stage
    import exp_fixed_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4,
    parameter int K     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 advance,
    input  logic                 src_valid,
    input  logic [WIDTH-1:0]     x,
    input  logic [TAG_W-1:0]     src_tag,
    input  logic [2*WIDTH-1:0]   src_acc,
    output logic                 dst_valid,
    output logic [TAG_W-1:0]     dst_tag,
    output logic [2*WIDTH-1:0]   dst_acc
);

    localparam int FRAC = WIDTH - 1;
    localparam int AW   = 2 * WIDTH;
    localparam int PW   = 3 * WIDTH;

    localparam logic signed [PW-1:0] RND  = PW'(1) << (FRAC - 1);
    localparam logic [AW-1:0]        COEF = AW'(coef(WIDTH, K));

    logic signed [PW-1:0] prod;
    logic [AW-1:0]        step;

    assign prod = PW'($signed(src_acc)) * PW'($signed(x));
    assign step = AW'((prod + RND) >>> FRAC) + COEF;

    always_ff @(posedge clk) begin
        if (rst) begin
            dst_valid <= 1'b0;
            dst_tag   <= '0;
            dst_acc   <= '0;
        end else if (advance) begin
            dst_valid <= src_valid;
            dst_tag   <= src_tag;
            dst_acc   <= step;
        end
    end

endmodule

// File: rtl/exp_fixed_pipe.sv
// Pipelined Taylor-series e^x on signed Q1.(WIDTH-1) input.
// Stage 0 loads x, tag and the top coefficient; stages 1..TERMS run Horner steps.
module exp_fixed_pipe
    import exp_fixed_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TERMS = 4,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x_in,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   exp_out,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 busy
);

    localparam int FRAC = WIDTH - 1;
    localparam int AW   = 2 * WIDTH;
    localparam int IFB  = if_bits(WIDTH);
    localparam int OSH  = IFB - FRAC;

    localparam logic [AW-1:0]        C_TOP = AW'(coef(WIDTH, TERMS));
    localparam logic signed [AW-1:0] ORND  = AW'(1) << (OSH - 1);

    logic             advance;
    logic             s0_valid;
    logic [TAG_W-1:0] s0_tag;
    logic [AW-1:0]    s0_acc;
    logic [WIDTH-1:0] x_q [0:TERMS-1];

    logic             v_a   [0:TERMS];
    logic [TAG_W-1:0] t_a   [0:TERMS];
    logic [AW-1:0]    acc_a [0:TERMS];

    logic               any_valid;
    logic signed [AW-1:0] acc_last;

    // A held output stalls every stage, so nothing upstream can be overwritten.
    assign advance  = enable & ~(out_valid & ~out_ready);
    assign in_ready = advance & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid <= 1'b0;
            s0_tag   <= '0;
            s0_acc   <= '0;
            for (int k = 0; k < TERMS; k++) begin
                x_q[k] <= '0;
            end
        end else if (advance) begin
            s0_valid <= in_valid;
            s0_tag   <= in_tag;
            s0_acc   <= C_TOP;
            x_q[0]   <= x_in;
            for (int k = 1; k < TERMS; k++) begin
                x_q[k] <= x_q[k-1];
            end
        end
    end

    assign v_a[0]   = s0_valid;
    assign t_a[0]   = s0_tag;
    assign acc_a[0] = s0_acc;

    for (genvar k = 1; k <= TERMS; k++) begin : g_stage
        exp_horner_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .K     (TERMS - k)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .advance   (advance),
            .src_valid (v_a[k-1]),
            .x         (x_q[k-1]),
            .src_tag   (t_a[k-1]),
            .src_acc   (acc_a[k-1]),
            .dst_valid (v_a[k]),
            .dst_tag   (t_a[k]),
            .dst_acc   (acc_a[k])
        );
    end

    always_comb begin
        any_valid = 1'b0;
        for (int k = 0; k <= TERMS; k++) begin
            any_valid = any_valid | v_a[k];
        end
    end

    assign acc_last  = acc_a[TERMS];
    assign busy      = any_valid & ~rst;
    assign out_valid = v_a[TERMS] & ~rst;
    assign out_tag   = rst ? '0 : t_a[TERMS];
    assign exp_out   = rst ? '0 : AW'((acc_last + ORND) >>> OSH);

endmodule
